pet_stats_engine: RTL and testbench
===================================

Name: pet_stats_engine

Overview:
- Producer side of the pet-status path. Owns the six 4-bit stat registers (hunger, happiness, health, hygiene, energy, social) that the status decoder consumes.
- Stats decay on a slow periodic tick, gated partly by the random byte. User button presses raise or lower stats.
- A small life-cycle FSM tracks the pet as AWAKE, SLEEPING or DEAD.
- Sits in the top level between ui_in/random generator and the states decoder.

Parameters:
- TICK_COUNT, 24'd10_000_000, clk cycles per decay tick.
- STAT_INIT, 4'd8, reset value of every stat.
- ACTION_GAIN, 4'd4, saturating increment applied by feed/play/social/heal.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; low freezes tick counter and ignores buttons
- btn  in  6  raw buttons: [0] feed, [1] play, [2] clean, [3] sleep, [4] social, [5] heal
- random  in  8  random byte from random generator
- hunger, happiness, health, hygiene, energy, social  out  4 each  stat registers (15 = best, 0 = worst)
- pet_state  out  2  0 AWAKE, 1 SLEEPING, 2 DEAD
- tick  out  1  one-cycle pulse per decay period
- action_ack  out  1  one-cycle pulse when an action is applied

Behaviour:
- Reset (async, rst_n low): all stats = STAT_INIT; pet_state = AWAKE; tick = 0; action_ack = 0; counter = 0; synchronizers cleared. Mid-operation reset aborts everything immediately.
- Tick counter:
  - Counts 0..TICK_COUNT-1 while ena is high, then wraps.
  - tick is registered high in the cycle after the counter wraps.
  - ena low holds the counter value.
- Buttons:
  - Each bit passes a 2-flop synchronizer, then rising-edge detect.
  - Stats and action_ack update on the 3rd rising clk edge after btn goes high.
  - A held button acts once.
- Simultaneous edges: fixed priority feed > play > clean > sleep > social > heal. One action per cycle; lower-priority edges in the same cycle are discarded.
- Actions in AWAKE:
  - feed: hunger + GAIN; hygiene - 1.
  - play: happiness + GAIN; energy - 2.
  - clean: hygiene = 15.
  - sleep: go to SLEEPING.
  - social: social + GAIN; happiness + 1.
  - heal: health + GAIN; happiness - 1.
- Actions in SLEEPING: only sleep is accepted, which wakes the pet (to AWAKE). All other buttons are ignored, with no ack.
- Decay on tick in AWAKE:
  - hunger -1 and energy -1 always.
  - happiness -1 if random[0]; hygiene -1 if random[1]; social -1 if random[2].
  - health -1 if hunger==0 or hygiene==0 (pre-update values); otherwise health +1 if random[7].
- Decay on tick in SLEEPING:
  - energy +2; hunger -1 if random[3]; all other stats hold.
  - Auto-wake to AWAKE when the post-update energy == 15.
- Arithmetic: each stat's update is computed as a signed 6-bit value, old + action_delta - decay_delta. The result is clamped to 0..15. This applies when an action and a tick land in the same cycle: both are applied, combined once.
- DEAD:
  - Entered the cycle after health reaches 0, from any state.
  - All stats freeze; buttons ignored; tick still pulses; no ack.
  - Exit only by reset.
- ena low: no actions applied and no decay. Synchronizers keep sampling, so no stale edge fires when ena rises.

Optional Feature:
- Macro: PET_FAST_TICK_EN.
- Defined: the effective tick period is 16 cycles, ignoring TICK_COUNT, for simulation and bring-up.
- Undefined: period = TICK_COUNT.
- No other behaviour changes.

Decomposition:
- Package pet_pkg holds:
  - pet_state encodings (AWAKE/SLEEPING/DEAD);
  - button index constants (BTN_FEED..BTN_HEAL);
  - STAT_MAX = 15;
  - action delta constants;
  - FAST_TICK = 16.
- Sub-module btn_sync_edge: 6-bit 2-flop synchronizer plus rising-edge detector, same async reset.

Test Plan:
- Reset release, then 40 idle cycles with PET_FAST_TICK_EN and random=0 -> two ticks; hunger=6, energy=6, happiness/hygiene/social=8, health=8.
- Pulse feed with hunger=13 -> hunger=15 (saturated) and hygiene=7 on the 3rd edge after the press; action_ack high for exactly 1 cycle.
- Press feed and play in the same cycle -> only feed is applied (happiness unchanged); a single ack.
- Sleep with energy=9 and random[3]=0 -> pet_state=1; after 3 ticks energy=15 and auto-wake to pet_state=0; a play press while sleeping gives no ack and no change.
- Drive hunger to 0 with health=1 -> next tick health=0, next cycle pet_state=2; feed then gives no change; rst_n low mid-cycle restores all stats to 8 asynchronously.
- Tick and heal in the same cycle with health=14 and random[7]=1 -> health=15 (14+4+1, clamped); happiness = old-1-random[0].

Source files
------------

// File: rtl/pet_pkg.sv
// Shared constants for the pet stats path: life-cycle encodings, button
// indices, stat slot indices, action/decay step sizes and the clamp helper.
package pet_pkg;

    typedef enum logic [1:0] {
        ST_AWAKE    = 2'd0,
        ST_SLEEPING = 2'd1,
        ST_DEAD     = 2'd2
    } pet_state_e;

    localparam int NUM_BTN  = 6;
    localparam int NUM_STAT = 6;

    localparam logic [2:0] BTN_FEED   = 3'd0;
    localparam logic [2:0] BTN_PLAY   = 3'd1;
    localparam logic [2:0] BTN_CLEAN  = 3'd2;
    localparam logic [2:0] BTN_SLEEP  = 3'd3;
    localparam logic [2:0] BTN_SOCIAL = 3'd4;
    localparam logic [2:0] BTN_HEAL   = 3'd5;

    // Slot order matches the output port order.
    localparam int S_HUNGER = 0;
    localparam int S_HAPPY  = 1;
    localparam int S_HEALTH = 2;
    localparam int S_HYGIENE = 3;
    localparam int S_ENERGY = 4;
    localparam int S_SOCIAL = 5;

    localparam logic [3:0] STAT_MAX = 4'd15;
    localparam int         FAST_TICK = 16;

    localparam logic signed [5:0] D_ZERO  = 6'sd0;
    localparam logic signed [5:0] D_ONE   = 6'sd1;
    localparam logic signed [5:0] D_TWO   = 6'sd2;
    localparam logic signed [5:0] D_CLEAN = 6'sd15;
    localparam logic signed [5:0] D_MAX   = 6'sd15;

    function automatic logic [3:0] clamp_stat(input logic signed [5:0] v);
        if (v < D_ZERO)
            return 4'd0;
        else if (v > D_MAX)
            return STAT_MAX;
        else
            return v[3:0];
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the raw button bus.
// It keeps sampling regardless of enable so a held button never fires late.
module btn_sync_edge
    import pet_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] rise
);

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/pet_stats_engine.sv
// Pet stat registers, decay tick and AWAKE/SLEEPING/DEAD life cycle.
// Define PET_FAST_TICK_EN to force a 16-cycle decay period for bring-up.
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter logic [23:0] TICK_COUNT  = 24'd10_000_000,
    parameter logic [3:0]  STAT_INIT   = 4'd8,
    parameter logic [3:0]  ACTION_GAIN = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] btn,
    input  logic [7:0] random,
    output logic [3:0] hunger,
    output logic [3:0] happiness,
    output logic [3:0] health,
    output logic [3:0] hygiene,
    output logic [3:0] energy,
    output logic [3:0] social,
    output logic [1:0] pet_state,
    output logic       tick,
    output logic       action_ack
);

`ifdef PET_FAST_TICK_EN
    localparam logic [23:0] PERIOD = 24'(FAST_TICK);
`else
    localparam logic [23:0] PERIOD = TICK_COUNT;
`endif
    localparam logic signed [5:0] GAIN = $signed({2'b00, ACTION_GAIN});

    logic [23:0]        cnt;
    logic               tick_q;
    logic               ack_q;
    pet_state_e         state_q, state_d;
    logic [3:0]         stat_q [NUM_STAT];
    logic [3:0]         stat_d [NUM_STAT];
    logic signed [5:0]  act_d  [NUM_STAT];
    logic signed [5:0]  dec_d  [NUM_STAT];
    logic [NUM_BTN-1:0] rise;
    logic [2:0]         act_sel;
    logic               act_valid;
    logic               action_ok;
    logic               decay;
    logic               wrap;
    logic               unused_random;

    assign unused_random = ^random[6:4];
    assign wrap  = (cnt == PERIOD - 24'd1);
    assign decay = tick_q && ena;

    btn_sync_edge u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .rise  (rise)
    );

    // Lowest index wins; the other edges of the same cycle are dropped.
    always_comb begin
        act_valid = |rise;
        act_sel   = 3'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (rise[i]) act_sel = 3'(i);
    end

    always_comb begin
        for (int i = 0; i < NUM_STAT; i++) begin
            act_d[i]  = D_ZERO;
            dec_d[i]  = D_ZERO;
            stat_d[i] = stat_q[i];
        end
        action_ok = 1'b0;
        state_d   = state_q;

        if (state_q == ST_AWAKE) begin
            if (act_valid && ena) begin
                action_ok = 1'b1;
                case (act_sel)
                    BTN_FEED:   begin act_d[S_HUNGER] = GAIN;  act_d[S_HYGIENE] = -D_ONE; end
                    BTN_PLAY:   begin act_d[S_HAPPY]  = GAIN;  act_d[S_ENERGY]  = -D_TWO; end
                    BTN_CLEAN:  act_d[S_HYGIENE] = D_CLEAN;
                    BTN_SLEEP:  state_d = ST_SLEEPING;
                    BTN_SOCIAL: begin act_d[S_SOCIAL] = GAIN;  act_d[S_HAPPY]   = D_ONE;  end
                    default:    begin act_d[S_HEALTH] = GAIN;  act_d[S_HAPPY]   = -D_ONE; end
                endcase
            end
            if (decay) begin
                dec_d[S_HUNGER]  = D_ONE;
                dec_d[S_ENERGY]  = D_ONE;
                dec_d[S_HAPPY]   = random[0] ? D_ONE : D_ZERO;
                dec_d[S_HYGIENE] = random[1] ? D_ONE : D_ZERO;
                dec_d[S_SOCIAL]  = random[2] ? D_ONE : D_ZERO;
                // Starvation or filth wears health down; otherwise it may recover.
                if (stat_q[S_HUNGER] == 4'd0 || stat_q[S_HYGIENE] == 4'd0)
                    dec_d[S_HEALTH] = D_ONE;
                else
                    dec_d[S_HEALTH] = random[7] ? -D_ONE : D_ZERO;
            end
        end else if (state_q == ST_SLEEPING) begin
            if (act_valid && ena && act_sel == BTN_SLEEP) begin
                action_ok = 1'b1;
                state_d   = ST_AWAKE;
            end
            if (decay) begin
                dec_d[S_ENERGY] = -D_TWO;
                dec_d[S_HUNGER] = random[3] ? D_ONE : D_ZERO;
            end
        end

        if (state_q != ST_DEAD)
            for (int i = 0; i < NUM_STAT; i++)
                stat_d[i] = clamp_stat($signed({2'b00, stat_q[i]}) + act_d[i] - dec_d[i]);

        if (state_q == ST_SLEEPING && decay && stat_d[S_ENERGY] == STAT_MAX)
            state_d = ST_AWAKE;
        if (state_q != ST_DEAD && stat_q[S_HEALTH] == 4'd0)
            state_d = ST_DEAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            state_q <= ST_AWAKE;
            for (int i = 0; i < NUM_STAT; i++)
                stat_q[i] <= STAT_INIT;
        end else begin
            if (ena)
                cnt <= wrap ? '0 : cnt + 24'd1;
            tick_q  <= ena && wrap;
            ack_q   <= action_ok;
            state_q <= state_d;
            for (int i = 0; i < NUM_STAT; i++)
                stat_q[i] <= stat_d[i];
        end
    end

    assign hunger     = stat_q[S_HUNGER];
    assign happiness  = stat_q[S_HAPPY];
    assign health     = stat_q[S_HEALTH];
    assign hygiene    = stat_q[S_HYGIENE];
    assign energy     = stat_q[S_ENERGY];
    assign social     = stat_q[S_SOCIAL];
    assign pet_state  = state_q;
    assign tick       = tick_q;
    assign action_ack = ack_q;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Bench for pet_stats_engine: directed scenarios then random traffic, all
// outputs compared every cycle against a behavioural model of the pet rules.
module tb_pet_stats_engine;

    localparam int P    = 16;
    localparam int GAIN = 4;
    localparam int INIT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [5:0] btn;
    logic [7:0] random;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic [1:0] pet_state;
    logic       tick, action_ack;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_stat [6];
    int         m_state;
    int         m_cnt;
    bit         m_tick;
    bit         m_ack;
    logic [5:0] hist [$];

    pet_stats_engine #(
        .TICK_COUNT  (24'(P)),
        .STAT_INIT   (4'(INIT)),
        .ACTION_GAIN (4'(GAIN))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn        (btn),
        .random     (random),
        .hunger     (hunger),
        .happiness  (happiness),
        .health     (health),
        .hygiene    (hygiene),
        .energy     (energy),
        .social     (social),
        .pet_state  (pet_state),
        .tick       (tick),
        .action_ack (action_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_stat[i] = INIT;
        m_state = 0;
        m_cnt   = 0;
        m_tick  = 0;
        m_ack   = 0;
        hist    = '{6'd0, 6'd0, 6'd0};
    endtask

    // One clock edge of the pet rules. stat order: hunger, happiness, health,
    // hygiene, energy, social. A press seen before edge k acts at edge k+2.
    task automatic model_edge();
        int         d [6];
        logic [5:0] rise;
        int         sel;
        bit         dec;
        int         nstate;
        bit         dies;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise = hist[1] & ~hist[2];
        sel = -1;
        for (int i = 5; i >= 0; i--) if (rise[i]) sel = i;
        dec = m_tick && ena;
        d = '{default: 0};
        nstate = m_state;
        m_ack = 0;
        dies = (m_state != 2) && (m_stat[2] == 0);
        if (m_state == 0) begin
            if (ena && sel >= 0) begin
                m_ack = 1;
                case (sel)
                    0: begin d[0] += GAIN; d[3] -= 1; end
                    1: begin d[1] += GAIN; d[4] -= 2; end
                    2: d[3] += 15;
                    3: nstate = 1;
                    4: begin d[5] += GAIN; d[1] += 1; end
                    default: begin d[2] += GAIN; d[1] -= 1; end
                endcase
            end
            if (dec) begin
                d[0] -= 1;
                d[4] -= 1;
                d[1] -= int'(random[0]);
                d[3] -= int'(random[1]);
                d[5] -= int'(random[2]);
                if (m_stat[0] == 0 || m_stat[3] == 0) d[2] -= 1;
                else d[2] += int'(random[7]);
            end
        end else if (m_state == 1) begin
            if (ena && sel == 3) begin
                m_ack = 1;
                nstate = 0;
            end
            if (dec) begin
                d[4] += 2;
                d[0] -= int'(random[3]);
            end
        end
        if (m_state != 2)
            for (int i = 0; i < 6; i++) m_stat[i] = clamp(m_stat[i] + d[i]);
        if (m_state == 1 && dec && m_stat[4] == 15) nstate = 0;
        if (dies) nstate = 2;
        m_state = nstate;
        m_tick = ena && (m_cnt == P - 1);
        if (ena) m_cnt = (m_cnt + 1) % P;
        hist.push_front(btn);
        void'(hist.pop_back());
    endtask

    task automatic compare_all();
        check("hunger",     int'(hunger),     m_stat[0]);
        check("happiness",  int'(happiness),  m_stat[1]);
        check("health",     int'(health),     m_stat[2]);
        check("hygiene",    int'(hygiene),    m_stat[3]);
        check("energy",     int'(energy),     m_stat[4]);
        check("social",     int'(social),     m_stat[5]);
        check("pet_state",  int'(pet_state),  m_state);
        check("tick",       int'(tick),       int'(m_tick));
        check("action_ack", int'(action_ack), int'(m_ack));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input logic [5:0] mask, input int hold);
        btn = mask;
        repeat (hold) step();
        btn = 6'd0;
        repeat (4) step();
    endtask

    // Reset lands mid-cycle; stats must return immediately, not at an edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_hunger", int'(hunger), INIT);
        check("async_rst_health", int'(health), INIT);
        check("async_rst_state",  int'(pet_state), 0);
        compare_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int  bound;
        bit  done;
        rst_n  = 1'b0;
        ena    = 1'b0;
        btn    = 6'd0;
        random = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        ena   = 1'b1;

        // idle decay with random=0: two ticks in 40 cycles
        repeat (40) step();
        check("idle_hunger", int'(hunger), 6);
        check("idle_energy", int'(energy), 6);
        check("idle_happy",  int'(happiness), 8);
        check("idle_health", int'(health), 8);
        check("idle_social", int'(social), 8);

        // repeated feeding, last one saturates hunger; held button acts once
        press(6'b000001, 6);
        press(6'b000001, 2);
        press(6'b000001, 3);
        check("feed_sat_hunger", int'(hunger), m_stat[0]);

        // simultaneous feed and play: only feed
        press(6'b000011, 3);

        // sleep, play while sleeping, then wait for auto-wake
        press(6'b001000, 2);
        check("sleeping", int'(pet_state), 1);
        press(6'b000010, 2);
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (m_state == 0) done = 1;
        end
        check("auto_wake_seen", int'(done), 1);

        // heal landing on the decay edge
        random = 8'h81;
        bound = 0;
        while (m_cnt != P - 2 && bound < 100) begin
            step();
            bound++;
        end
        check("align_bound", int'(bound < 100), 1);
        press(6'b100000, 1);

        // starve to death, then buttons do nothing, then async reset
        random = 8'h00;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (m_state == 2) done = 1;
        end
        check("death_seen", int'(done), 1);
        step();
        check("dead_state", int'(pet_state), 2);
        press(6'b000001, 2);
        async_reset();
        ena = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            random = 8'($urandom);
            ena    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                btn = btn ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
